seq_divider32: RTL

//  Multi-cycle unsigned/signed integer divider for the MIPS datapath (DIVU/DIV -> LO/HI).

---
 rtl/seq_divider32.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider (one quotient bit per clock) producing LO/HI results.
// Optional signed division is enabled by defining DIV_SIGNED_EN (adds the signed_op input).
module seq_divider32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_sr;
    logic [WIDTH-1:0] rem_sr;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic             neg_dvd_c;
    logic             neg_dvs_c;
    logic [WIDTH-1:0] mag_dvd_c;
    logic [WIDTH-1:0] mag_dvs_c;
    logic [WIDTH:0]   rem_shift_c;
    logic [WIDTH:0]   diff_c;
    logic             ge_c;
    logic [WIDTH-1:0] q_next_c;
    logic [WIDTH-1:0] rem_next_c;
    logic [WIDTH-1:0] q_final_c;
    logic [WIDTH-1:0] rem_final_c;

    // Operand sign extraction; the unsigned build treats every operand as non-negative
`ifdef DIV_SIGNED_EN
    assign neg_dvd_c = signed_op & dividend[WIDTH-1];
    assign neg_dvs_c = signed_op & divisor[WIDTH-1];
`else
    assign neg_dvd_c = 1'b0;
    assign neg_dvs_c = 1'b0;
`endif

    assign mag_dvd_c = neg_dvd_c ? (~dividend + WIDTH'(1)) : dividend;
    assign mag_dvs_c = neg_dvs_c ? (~divisor + WIDTH'(1)) : divisor;

    // One restoring step; the extra top bit keeps the compare exact for large divisors
    assign rem_shift_c = {rem_sr, q_sr[WIDTH-1]};
    assign diff_c      = rem_shift_c - {1'b0, dvs};
    assign ge_c        = ~diff_c[WIDTH];
    assign rem_next_c  = ge_c ? diff_c[WIDTH-1:0] : rem_shift_c[WIDTH-1:0];
    assign q_next_c    = {q_sr[WIDTH-2:0], ge_c};

    // Sign fix-up on the final step: quotient by sign mismatch, remainder follows dividend
    assign q_final_c   = neg_q ? (~q_next_c + WIDTH'(1)) : q_next_c;
    assign rem_final_c = neg_r ? (~rem_next_c + WIDTH'(1)) : rem_next_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            q_sr        <= '0;
            rem_sr      <= '0;
            dvs         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_RUN: begin
                    q_sr   <= q_next_c;
                    rem_sr <= rem_next_c;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        quotient  <= q_final_c;
                        remainder <= rem_final_c;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE also emits the pulse
                    done <= (state == S_DONE);
                    if (start) begin
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            state       <= S_DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state  <= S_RUN;
                            busy   <= 1'b1;
                            count  <= '0;
                            q_sr   <= mag_dvd_c;
                            rem_sr <= '0;
                            dvs    <= mag_dvs_c;
                            neg_q  <= neg_dvd_c ^ neg_dvs_c;
                            neg_r  <= neg_dvd_c;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
